fetch_redirect_ctrl: RTL and testbench

Sequencer for the fetch PC and the branch predictor.
- Owns the fetch PC register and steers it with the predictor's combinational prediction.
- Carries each fetched instruction's prediction down the fetch→rf→execute pipeline.
- Compares the carried prediction against the resolved branch outcome in execute, and on a mismatch issues a one-cycle flush plus a PC redirect.
- Produces the stage-valid strobes that qualify predictor training, and supports a halt/drain sequence.

---
 rtl/fetch_redirect_ctrl.sv | 154 +++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: fetch PC sequencer for the branch predictor.
// Owns the fetch PC, carries each fetch's prediction through rf and execute,
// checks it against the resolved outcome and redirects fetch on a mismatch.
// Optional feature macro: BP_STATS_EN (branch / mispredict counters).
//
// state | meaning
// BOOT  | one idle cycle after reset, no fetch
// RUN   | fetching, PC steered by the predictor
// DRAIN | fetch stopped, fetch_pc held, older stages keep advancing
module fetch_redirect_ctrl #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            bp_prediction,
    input  logic [PC_W-1:0] bp_prediction_pc,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    output logic [PC_W-1:0] fetch_pc,
    output logic            fetch_valid,
    output logic            rf_valid,
    output logic            ex_valid,
    output logic [PC_W-1:0] ex_pc,
    output logic            flush,
    output logic            halted,
    output logic [15:0]     branch_count,
    output logic [15:0]     mispredict_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PC_W-1:0] rf_pc;
    logic            rf_pred_taken;
    logic [PC_W-1:0] rf_pred_pc;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_pc;

    logic            pred_wrong;
    logic            mispredict;
    logic [PC_W-1:0] correct_pc;

    // Compare the carried prediction with the resolved outcome in execute.
    // A predicted-taken non-branch is a partial-tag alias and also redirects.
    always_comb begin
        pred_wrong = 1'b0;
        if (ex_is_branch)
            pred_wrong = (ex_pred_taken != ex_taken) ||
                         (ex_taken && (ex_pred_pc != ex_target));
        else
            pred_wrong = ex_pred_taken;
        mispredict = ex_valid && !stall && !reset && pred_wrong;
        correct_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + PC_W'(2);
    end

    assign flush  = mispredict;
    assign halted = (state == DRAIN) && !rf_valid && !ex_valid;

    // Next-state and fetch qualification.
    always_comb begin
        state_nxt   = state;
        fetch_valid = 1'b0;
        case (state)
            BOOT: begin
                if (!stall)
                    state_nxt = RUN;
            end
            RUN: begin
                fetch_valid = 1'b1;
                if (halt_req && !stall)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!halt_req && !stall)
                    state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    // Fetch PC and the rf/execute stage registers; a redirect empties both stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc      <= '0;
            rf_valid      <= 1'b0;
            rf_pc         <= '0;
            rf_pred_taken <= 1'b0;
            rf_pred_pc    <= '0;
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_pred_taken <= 1'b0;
            ex_pred_pc    <= '0;
        end else if (!stall) begin
            rf_pc         <= fetch_pc;
            rf_pred_taken <= bp_prediction;
            rf_pred_pc    <= bp_prediction_pc;
            ex_pc         <= rf_pc;
            ex_pred_taken <= rf_pred_taken;
            ex_pred_pc    <= rf_pred_pc;
            if (mispredict) begin
                fetch_pc <= correct_pc;
                rf_valid <= 1'b0;
                ex_valid <= 1'b0;
            end else begin
                rf_valid <= fetch_valid;
                ex_valid <= rf_valid;
                if (state == RUN)
                    fetch_pc <= bp_prediction ? bp_prediction_pc : fetch_pc + PC_W'(2);
            end
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] branch_cnt_q;
    logic [15:0] mispredict_cnt_q;

    // Saturating counters of resolved branches and mispredictions.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (!stall) begin
            if (ex_valid && ex_is_branch && (branch_cnt_q != 16'hFFFF))
                branch_cnt_q <= branch_cnt_q + 16'd1;
            if (mispredict && (mispredict_cnt_q != 16'hFFFF))
                mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispredict_cnt_q;
`else
    assign branch_count     = 16'h0000;
    assign mispredict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: per-cycle vector table with a queue of
// expected outputs, plus hand-written multi-cycle corner sequences.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        bp_prediction = 1'b0;
    logic [15:0] bp_prediction_pc = '0;
    logic        ex_is_branch = 1'b0;
    logic        ex_taken = 1'b0;
    logic [15:0] ex_target = '0;
    logic [15:0] fetch_pc;
    logic        fetch_valid;
    logic        rf_valid;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic        flush;
    logic        halted;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int checks = 0;
    int failures = 0;

    fetch_redirect_ctrl #(.PC_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .bp_prediction(bp_prediction), .bp_prediction_pc(bp_prediction_pc),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .rf_valid(rf_valid),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .flush(flush), .halted(halted),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        halt;
        logic        bp;
        logic [15:0] bp_pc;
        logic        br;
        logic        tk;
        logic [15:0] tgt;
        logic [15:0] e_fpc;
        logic        e_fv;
        logic        e_rfv;
        logic        e_exv;
        logic [15:0] e_expc;
        logic        e_flush;
        logic        e_halted;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t v(input logic st, hl, bp, input logic [15:0] bpc,
                               input logic br, tk, input logic [15:0] tgt,
                               input logic [15:0] fpc, input logic fv, rfv, exv,
                               input logic [15:0] expc, input logic fl, hd);
        vec_t r;
        r.stall = st;  r.halt = hl;  r.bp = bp;  r.bp_pc = bpc;
        r.br = br;  r.tk = tk;  r.tgt = tgt;
        r.e_fpc = fpc;  r.e_fv = fv;  r.e_rfv = rfv;  r.e_exv = exv;
        r.e_expc = expc;  r.e_flush = fl;  r.e_halted = hd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, compare that cycle's outputs, then move to the next cycle.
    task automatic step(input vec_t x, input int idx);
        vec_t e;
        stall = x.stall;  halt_req = x.halt;
        bp_prediction = x.bp;  bp_prediction_pc = x.bp_pc;
        ex_is_branch = x.br;  ex_taken = x.tk;  ex_target = x.tgt;
        exp_q.push_back(x);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("fetch_pc[%0d]", idx), {16'h0, fetch_pc}, {16'h0, e.e_fpc});
        chk($sformatf("fetch_valid[%0d]", idx), {31'h0, fetch_valid}, {31'h0, e.e_fv});
        chk($sformatf("rf_valid[%0d]", idx), {31'h0, rf_valid}, {31'h0, e.e_rfv});
        chk($sformatf("ex_valid[%0d]", idx), {31'h0, ex_valid}, {31'h0, e.e_exv});
        chk($sformatf("flush[%0d]", idx), {31'h0, flush}, {31'h0, e.e_flush});
        chk($sformatf("halted[%0d]", idx), {31'h0, halted}, {31'h0, e.e_halted});
        if (e.e_exv)
            chk($sformatf("ex_pc[%0d]", idx), {16'h0, ex_pc}, {16'h0, e.e_expc});
        @(negedge clk);
    endtask

    // Apply reset for n edges (with the given stall level) and check the reset values.
    task automatic do_reset(input int n, input logic st);
        reset = 1'b1;
        stall = st;
        halt_req = 1'b0;
        bp_prediction = 1'b0;
        ex_is_branch = 1'b0;
        ex_taken = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        chk("rst_fetch_pc", {16'h0, fetch_pc}, 32'h0);
        chk("rst_ex_pc", {16'h0, ex_pc}, 32'h0);
        chk("rst_valids", {29'h0, fetch_valid, rf_valid, ex_valid}, 32'h0);
        chk("rst_flush_halted", {30'h0, flush, halted}, 32'h0);
        chk("rst_counters", {branch_count, mispredict_count}, 32'h0);
        reset = 1'b0;
        stall = 1'b0;
    endtask

    int exp_br;
    int exp_mp;

    initial begin
        @(negedge clk);
        do_reset(2, 1'b0);

        //        st hl bp bp_pc    br tk tgt      fpc      fv rfv exv ex_pc    fl hd
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0000, 0,0,0,16'h0000, 0,0)); // BOOT
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0000, 1,0,0,16'h0000, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0002, 1,1,0,16'h0000, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0004, 1,1,1,16'h0000, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0006, 1,1,1,16'h0002, 0,0));
        tbl.push_back(v(0,0,1,16'h0040, 0,0,16'h0000, 16'h0008, 1,1,1,16'h0004, 0,0)); // predict taken
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0040, 1,1,1,16'h0006, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'h0040, 16'h0042, 1,1,1,16'h0008, 0,0)); // correct
        tbl.push_back(v(0,0,1,16'h0010, 0,0,16'h0000, 16'h0044, 1,1,1,16'h0040, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0010, 1,1,1,16'h0042, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'h0010, 16'h0012, 1,1,1,16'h0044, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'h0080, 16'h0014, 1,1,1,16'h0010, 1,0)); // dir mispredict
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0080, 1,0,0,16'h0000, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0082, 1,1,0,16'h0000, 0,0));
        tbl.push_back(v(0,0,1,16'h0100, 0,0,16'h0000, 16'h0084, 1,1,1,16'h0080, 0,0));
        tbl.push_back(v(0,0,1,16'h0020, 0,0,16'h0000, 16'h0100, 1,1,1,16'h0082, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'h0100, 16'h0020, 1,1,1,16'h0084, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0022, 1,1,1,16'h0100, 1,0)); // alias
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0102, 1,0,0,16'h0000, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0104, 1,1,0,16'h0000, 0,0));
        tbl.push_back(v(1,0,0,16'h0000, 1,1,16'h0200, 16'h0106, 1,1,1,16'h0102, 0,0)); // stalled
        tbl.push_back(v(1,0,0,16'h0000, 1,1,16'h0200, 16'h0106, 1,1,1,16'h0102, 0,0));
        tbl.push_back(v(1,0,0,16'h0000, 1,1,16'h0200, 16'h0106, 1,1,1,16'h0102, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'h0200, 16'h0106, 1,1,1,16'h0102, 1,0)); // released
        tbl.push_back(v(0,0,1,16'hFFFE, 0,0,16'h0000, 16'h0200, 1,0,0,16'h0000, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'hFFFE, 1,1,0,16'h0000, 0,0));
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'hFFFE, 16'h0000, 1,1,1,16'h0200, 0,0)); // wrapped
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0002, 1,1,1,16'hFFFE, 0,0));
        tbl.push_back(v(0,1,0,16'h0000, 0,0,16'h0000, 16'h0004, 1,1,1,16'h0000, 0,0)); // halt
        tbl.push_back(v(0,1,0,16'h0000, 0,0,16'h0000, 16'h0006, 0,1,1,16'h0002, 0,0));
        tbl.push_back(v(0,1,0,16'h0000, 0,0,16'h0000, 16'h0006, 0,0,1,16'h0004, 0,0));
        tbl.push_back(v(0,1,0,16'h0000, 0,0,16'h0000, 16'h0006, 0,0,0,16'h0000, 0,1));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0006, 0,0,0,16'h0000, 0,1));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0006, 1,0,0,16'h0000, 0,0)); // resumed
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0008, 1,1,0,16'h0000, 0,0));

        foreach (tbl[i]) step(tbl[i], i);

`ifdef BP_STATS_EN
        exp_br = 6;
        exp_mp = 3;
`else
        exp_br = 0;
        exp_mp = 0;
`endif
        chk("branch_count", {16'h0, branch_count}, exp_br);
        chk("mispredict_count", {16'h0, mispredict_count}, exp_mp);

        // Reset while stalled must still take effect.
        stall = 1'b1;
        @(negedge clk);
        do_reset(1, 1'b1);

        // Mispredict coinciding with halt_req, then a mispredict while draining.
        step(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0000, 0,0,0,16'h0000, 0,0), 100);
        step(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0000, 1,0,0,16'h0000, 0,0), 101);
        step(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0002, 1,1,0,16'h0000, 0,0), 102);
        step(v(0,1,0,16'h0000, 1,1,16'h0300, 16'h0004, 1,1,1,16'h0000, 1,0), 103);
        step(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0300, 0,0,0,16'h0000, 0,1), 104);
        step(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0300, 1,0,0,16'h0000, 0,0), 105);
        step(v(0,1,0,16'h0000, 0,0,16'h0000, 16'h0302, 1,1,0,16'h0000, 0,0), 106);
        step(v(0,1,0,16'h0000, 1,1,16'h0400, 16'h0304, 0,1,1,16'h0300, 1,0), 107);
        step(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0400, 0,0,0,16'h0000, 0,1), 108);
        step(v(0,0,0,16'h0000, 0,0,16'h0000, 16'h0400, 1,0,0,16'h0000, 0,0), 109);

`ifdef BP_STATS_EN
        exp_br = 2;
        exp_mp = 2;
`endif
        chk("branch_count_2", {16'h0, branch_count}, exp_br);
        chk("mispredict_count_2", {16'h0, mispredict_count}, exp_mp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
